rob_commit_unit: RTL and testbench
==================================

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
- REQ-001 The block SHALL take parameter ROB_WIDTH_BIT, default 3: ROB id width, giving depth D = 2^ROB_WIDTH_BIT.
- REQ-002 The block SHALL have the following ports (W = ROB_WIDTH_BIT):
  - clk_in  in  1  system clock.
  - rst_in  in  1  synchronous, active-low reset.
  - rdy_in  in  1  pause; all state frozen when low.
  - issue_valid  in  1  decoder offers an instruction.
  - issue_rd  in  5  destination register; 0 means none.
  - issue_is_br  in  1  instruction is a conditional branch.
  - issue_pred_taken  in  1  predictor's direction.
  - issue_pc  in  32  instruction PC.
  - issue_ready  out  1  an offered instruction is accepted this cycle.
  - new_reg_id  out  5  rename destination to the register file.
  - new_ROB_id  out  W  allocated entry id (tail).
  - cdb_valid  in  1  result broadcast.
  - cdb_rob_id  in  W  target entry.
  - cdb_val  in  32  result value, or branch target.
  - cdb_br_taken  in  1  actual branch direction.
  - rs1_id, rs2_id  in  W  operand entry lookups.
  - rs1_ready, rs2_ready  out  1  looked-up value available.
  - rs1_val, rs2_val  out  32  looked-up value.
  - write_reg_id  out  5  commit destination; 0 means no write.
  - write_ROB_id  out  W  committing entry id.
  - write_val  out  32  commit value.
  - clear_flag  out  1  mispredict flush.
  - redirect_pc  out  32  fetch restart PC, valid with clear_flag.

Function
- REQ-003 The block SHALL hold a circular buffer of D entries: busy, ready, rd, is_br, pred_taken, pc, val, br_taken; plus head, tail and a count of 0..D.
- REQ-004 full SHALL be count==D and empty SHALL be count==0; head and tail SHALL wrap modulo D.
- REQ-005 issue_ready SHALL equal rdy_in && !full && !clear_flag.
- REQ-006 An issue is accepted when issue_valid && issue_ready, evaluated combinationally on pre-edge state.
- REQ-007 On an accepted issue, the entry at tail SHALL be written at the edge with busy=1 and ready=0, and tail SHALL increment.
- REQ-008 new_reg_id SHALL be issue_rd when an issue is accepted, else 0; new_ROB_id SHALL always be tail.
- REQ-009 cdb_valid to a busy entry SHALL set ready=1 and store val and br_taken at the edge; cdb_valid to a non-busy entry SHALL be ignored.
- REQ-010 rsN_ready SHALL be entry(rsN_id).ready || (cdb_valid && cdb_rob_id==rsN_id); rsN_val SHALL select cdb_val on the bypass, else entry val. Both are combinational.
- REQ-011 Commit SHALL be combinational from the head entry: when rdy_in && !empty && head.ready, write_reg_id=head.rd, write_ROB_id=head, write_val=head.val, and head SHALL advance at the edge. Otherwise write_reg_id SHALL be 0.
- REQ-012 At most one commit per cycle; a head made ready by the CDB in cycle N SHALL commit no earlier than cycle N+1.
- REQ-013 Issue and commit in the same cycle: count SHALL be unchanged and both pointers SHALL advance. Full status SHALL use pre-edge state, so a full ROB rejects the issue even if a commit occurs.
- REQ-014 A committing branch with br_taken != pred_taken SHALL assert clear_flag for that cycle.
- REQ-015 redirect_pc SHALL be head.val if br_taken, else head.pc+4 (32-bit wrap).
- REQ-016 At the clear_flag edge, head, tail and count SHALL become 0 and all busy/ready bits SHALL clear; CDB updates that cycle SHALL be dropped.
- REQ-017 A correctly predicted branch SHALL commit normally with write_reg_id=rd (0 for conditional branches).
- REQ-018 While rdy_in is low, no state SHALL change, and new_reg_id, write_reg_id and clear_flag SHALL be 0.

Reset
- REQ-019 When rst_in is low at an edge, head, tail and count SHALL be 0 and all busy/ready bits SHALL be 0, taking priority over all other activity including mid-flush.
- REQ-020 After reset: issue_ready=1 (when rdy_in=1), write_reg_id=0, clear_flag=0, new_ROB_id=0.

Verification
- REQ-021 Bench SHALL cover: reset, then issue rd=5 pc=0x100 -> new_reg_id=5, new_ROB_id=0; next issue gets id 1.
- REQ-022 Bench SHALL cover: CDB id0 val=0x2A, then next cycle -> write_reg_id=5, write_ROB_id=0, write_val=0x2A; count decrements.
- REQ-023 Bench SHALL cover: issue 8 instructions with W=3 -> issue_ready=0 on the 9th. Commit+issue in the same cycle while full -> issue rejected; next cycle accepted with id 0 (wrap).
- REQ-024 Bench SHALL cover: lookup rs1_id=2 while CDB id2 val=7 -> rs1_ready=1, rs1_val=7 in the same cycle.
- REQ-025 Bench SHALL cover: branch pc=0x200, pred=0, CDB taken=1 val=0x300 -> commit cycle clear_flag=1, redirect_pc=0x300; next cycle empty, new_ROB_id=0. With pred=1, taken=0 -> redirect_pc=0x204.
- REQ-026 Bench SHALL cover: rdy_in=0 with a ready head -> no commit and pointers hold. rst_in=0 with 3 entries busy -> empty the next cycle.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit
//   Reorder buffer with in-order commit and mispredict flush.
//   Instructions are allocated at the tail when the decoder offers one and the
//   buffer has room, results arrive over the CDB, and the oldest entry retires
//   from the head once its result is ready. A committing conditional branch
//   whose resolved direction disagrees with the prediction raises clear_flag
//   for that cycle and empties the whole buffer at the edge.
//
// Ports
//   clk_in, rst_in       clock, synchronous active-low reset
//   rdy_in               global pause; when low nothing changes
//   issue_*              decoder offer (valid, rd, branch flag, prediction, pc)
//   issue_ready          offer accepted this cycle
//   new_reg_id           rename destination (0 when nothing accepted)
//   new_ROB_id           entry id that an accepted issue receives (tail)
//   cdb_*                result broadcast (id, value/target, branch direction)
//   rs1_id/rs2_id        operand lookups, answered combinationally with bypass
//   rs1_/rs2_ready/val   lookup result
//   write_reg_id         commit destination (0 = no write)
//   write_ROB_id         committing entry id (head)
//   write_val            commit value
//   clear_flag           mispredict flush, this cycle
//   redirect_pc          fetch restart address, valid with clear_flag

module rob_commit_unit #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,

  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_br,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_pc,
  output logic                     issue_ready,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,

  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_br_taken,

  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,

  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  localparam int D = 1 << ROB_WIDTH_BIT;
  // Occupancy needs one extra bit so that "full" (D) is distinct from "empty" (0).
  localparam logic [ROB_WIDTH_BIT:0] DEPTH = {1'b1, {ROB_WIDTH_BIT{1'b0}}};

  // Restart address after a mispredict: the resolved target when the branch
  // was actually taken, otherwise the fall-through instruction.
  function automatic logic [31:0] redirect_target(input logic        taken,
                                                  input logic [31:0] target,
                                                  input logic [31:0] pc);
    return taken ? target : (pc + 32'd4);
  endfunction

  // Control state (reset)
  logic [D-1:0]               busy_p0;
  logic [D-1:0]               ready_p0;
  logic [ROB_WIDTH_BIT-1:0]   head_p0;
  logic [ROB_WIDTH_BIT-1:0]   tail_p0;
  logic [ROB_WIDTH_BIT:0]     count_p0;

  // Entry payload (never reset; only meaningful while busy)
  logic [4:0]                 rd_p0    [0:D-1];
  logic [31:0]                pc_p0    [0:D-1];
  logic [31:0]                val_p0   [0:D-1];
  logic [D-1:0]               is_br_p0;
  logic [D-1:0]               pred_p0;
  logic [D-1:0]               brt_p0;

  logic full;
  logic empty;
  logic commit;
  logic issue_acc;
  logic cdb_hit;
  logic rs1_byp;
  logic rs2_byp;

  always_comb begin
    full       = (count_p0 == DEPTH);
    empty      = (count_p0 == '0);

    // Commit looks only at registered readiness, so a result landing on the
    // CDB this cycle retires the head at the earliest on the next cycle.
    commit     = rdy_in && !empty && ready_p0[head_p0];
    clear_flag = commit && is_br_p0[head_p0] && (brt_p0[head_p0] != pred_p0[head_p0]);
    redirect_pc = redirect_target(brt_p0[head_p0], val_p0[head_p0], pc_p0[head_p0]);

    // Full is judged on pre-edge occupancy: a commit in the same cycle does
    // not open a slot for the instruction being offered.
    issue_ready = rdy_in && !full && !clear_flag;
    issue_acc   = issue_valid && issue_ready;
    new_reg_id  = issue_acc ? issue_rd : 5'd0;
    new_ROB_id  = tail_p0;

    write_reg_id = commit ? rd_p0[head_p0] : 5'd0;
    write_ROB_id = head_p0;
    write_val    = val_p0[head_p0];

    // Results for entries that are not in flight (stale ids) are ignored.
    cdb_hit = cdb_valid && busy_p0[cdb_rob_id];

    // Operand lookup forwards a same-cycle broadcast ahead of the stored value.
    rs1_byp   = cdb_valid && (cdb_rob_id == rs1_id);
    rs2_byp   = cdb_valid && (cdb_rob_id == rs2_id);
    rs1_ready = ready_p0[rs1_id] || rs1_byp;
    rs2_ready = ready_p0[rs2_id] || rs2_byp;
    rs1_val   = rs1_byp ? cdb_val : val_p0[rs1_id];
    rs2_val   = rs2_byp ? cdb_val : val_p0[rs2_id];
  end

  // ---- state update edge: control ----
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_p0  <= '0;
      ready_p0 <= '0;
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        // Flush discards everything younger than (and including) the branch;
        // any CDB traffic this cycle belongs to squashed work.
        busy_p0  <= '0;
        ready_p0 <= '0;
        head_p0  <= '0;
        tail_p0  <= '0;
        count_p0 <= '0;
      end else begin
        if (cdb_hit) begin
          ready_p0[cdb_rob_id] <= 1'b1;
        end
        // Commit and issue never touch the same slot: issuing into the head
        // slot would require a full buffer, which rejects the issue.
        if (commit) begin
          busy_p0[head_p0]  <= 1'b0;
          ready_p0[head_p0] <= 1'b0;
          head_p0           <= head_p0 + 1'b1;
        end
        if (issue_acc) begin
          busy_p0[tail_p0]  <= 1'b1;
          ready_p0[tail_p0] <= 1'b0;
          tail_p0           <= tail_p0 + 1'b1;
        end
        if (issue_acc && !commit) begin
          count_p0 <= count_p0 + 1'b1;
        end else if (commit && !issue_acc) begin
          count_p0 <= count_p0 - 1'b1;
        end
      end
    end
  end

  // ---- state update edge: entry payload ----
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_flag) begin
      if (cdb_hit) begin
        val_p0[cdb_rob_id] <= cdb_val;
        brt_p0[cdb_rob_id] <= cdb_br_taken;
      end
      if (issue_acc) begin
        rd_p0[tail_p0]    <= issue_rd;
        pc_p0[tail_p0]    <= issue_pc;
        is_br_p0[tail_p0] <= issue_is_br;
        pred_p0[tail_p0]  <= issue_pred_taken;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

  localparam int W = 3;
  localparam int D = 1 << W;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_is_br;
  logic          issue_pred_taken;
  logic [31:0]   issue_pc;
  logic          issue_ready;
  logic [4:0]    new_reg_id;
  logic [W-1:0]  new_ROB_id;
  logic          cdb_valid;
  logic [W-1:0]  cdb_rob_id;
  logic [31:0]   cdb_val;
  logic          cdb_br_taken;
  logic [W-1:0]  rs1_id;
  logic [W-1:0]  rs2_id;
  logic          rs1_ready;
  logic          rs2_ready;
  logic [31:0]   rs1_val;
  logic [31:0]   rs2_val;
  logic [4:0]    write_reg_id;
  logic [W-1:0]  write_ROB_id;
  logic [31:0]   write_val;
  logic          clear_flag;
  logic [31:0]   redirect_pc;

  int total = 0;
  int bad   = 0;

  rob_commit_unit #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
    .issue_ready(issue_ready), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .cdb_br_taken(cdb_br_taken),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the buffer is an ordered queue of in-flight instructions,
  // oldest first; the id of q[k] is (head_id + k) mod D.
  typedef struct {
    logic [4:0]  rd;
    bit          is_br;
    bit          pred;
    bit          brt;
    bit          rdy;
    logic [31:0] pc;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   head_id = 0;

  bit          m_commit, m_clear, m_iready, m_acc;
  logic [4:0]  m_new_reg, m_wreg;
  int          m_new_id, m_wid;
  logic [31:0] m_wval, m_redirect;
  bit          m_rs1_chk, m_rs1_rdy, m_rs2_chk, m_rs2_rdy;
  logic [31:0] m_rs1_val, m_rs2_val;

  task automatic model_comb();
    int sz;
    int p1;
    int p2;
    bit b1;
    bit b2;
    sz = q.size();
    m_commit = rdy_in && (sz > 0) && q[0].rdy;
    m_clear  = m_commit && q[0].is_br && (q[0].brt != q[0].pred);
    m_redirect = 32'd0;
    m_wval     = 32'd0;
    if (sz > 0) begin
      m_redirect = q[0].brt ? q[0].val : q[0].pc + 32'd4;
      m_wval     = q[0].val;
    end
    m_iready  = rdy_in && (sz < D) && !m_clear;
    m_acc     = issue_valid && m_iready;
    m_new_reg = m_acc ? issue_rd : 5'd0;
    m_new_id  = (head_id + sz) % D;
    m_wreg    = m_commit ? q[0].rd : 5'd0;
    m_wid     = head_id;
    p1 = (int'(rs1_id) - head_id + D) % D;
    p2 = (int'(rs2_id) - head_id + D) % D;
    b1 = cdb_valid && (cdb_rob_id == rs1_id);
    b2 = cdb_valid && (cdb_rob_id == rs2_id);
    m_rs1_chk = b1 || (p1 < sz);
    m_rs2_chk = b2 || (p2 < sz);
    m_rs1_rdy = b1 || ((p1 < sz) && q[p1].rdy);
    m_rs2_rdy = b2 || ((p2 < sz) && q[p2].rdy);
    m_rs1_val = b1 ? cdb_val : ((p1 < sz) ? q[p1].val : 32'd0);
    m_rs2_val = b2 ? cdb_val : ((p2 < sz) ? q[p2].val : 32'd0);
  endtask

  task automatic model_update();
    ent_t e;
    int   p;
    model_comb();
    if (!rst_in) begin
      q.delete();
      head_id = 0;
    end else if (rdy_in) begin
      if (m_clear) begin
        q.delete();
        head_id = 0;
      end else begin
        p = (int'(cdb_rob_id) - head_id + D) % D;
        if (cdb_valid && p < q.size()) begin
          e = q[p];
          e.rdy = 1'b1;
          e.val = cdb_val;
          e.brt = cdb_br_taken;
          q[p] = e;
        end
        if (m_commit) begin
          void'(q.pop_front());
          head_id = (head_id + 1) % D;
        end
        if (m_acc) begin
          e.rd = issue_rd; e.is_br = issue_is_br; e.pred = issue_pred_taken;
          e.brt = 1'b0; e.rdy = 1'b0; e.pc = issue_pc; e.val = 32'd0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk_in);
    model_comb();
  endtask

  task automatic cycle_end();
    model_update();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_is_br = 1'b0;
    issue_pred_taken = 1'b0; issue_pc = 32'd0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_val = 32'd0; cdb_br_taken = 1'b0;
    rs1_id = '0; rs2_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b0;
    settle();
    cycle_end();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0h want=1", issue_ready); end
    total++; if (write_reg_id !== 5'd0) begin bad++; $display("FAIL reset_write_reg_id got=%0h want=0", write_reg_id); end
    total++; if (clear_flag !== 1'b0) begin bad++; $display("FAIL reset_clear_flag got=%0h want=0", clear_flag); end
    total++; if (new_ROB_id !== 3'd0) begin bad++; $display("FAIL reset_new_ROB_id got=%0h want=0", new_ROB_id); end
    cycle_end();
  endtask

  task automatic test_issue_basic();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_pc = 32'h100;
    settle();
    total++; if (new_reg_id !== 5'd5) begin bad++; $display("FAIL issue0_new_reg_id got=%0h want=5", new_reg_id); end
    total++; if (new_ROB_id !== 3'd0) begin bad++; $display("FAIL issue0_new_ROB_id got=%0h want=0", new_ROB_id); end
    cycle_end();
    issue_rd = 5'd6; issue_pc = 32'h104;
    settle();
    total++; if (new_ROB_id !== 3'd1) begin bad++; $display("FAIL issue1_new_ROB_id got=%0h want=1", new_ROB_id); end
    total++; if (new_reg_id !== 5'd6) begin bad++; $display("FAIL issue1_new_reg_id got=%0h want=6", new_reg_id); end
    cycle_end();
    issue_valid = 1'b0;
  endtask

  task automatic test_cdb_commit();
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h2A;
    settle();
    total++; if (write_reg_id !== 5'd0) begin bad++; $display("FAIL cdb_same_cycle_commit got=%0h want=0", write_reg_id); end
    cycle_end();
    cdb_valid = 1'b0;
    settle();
    total++; if (write_reg_id !== 5'd5) begin bad++; $display("FAIL commit_write_reg_id got=%0h want=5", write_reg_id); end
    total++; if (write_ROB_id !== 3'd0) begin bad++; $display("FAIL commit_write_ROB_id got=%0h want=0", write_ROB_id); end
    total++; if (write_val !== 32'h2A) begin bad++; $display("FAIL commit_write_val got=%0h want=2a", write_val); end
    cycle_end();
    settle();
    // one entry left (id 1): head=1, tail=2
    total++; if (write_ROB_id !== 3'd1) begin bad++; $display("FAIL post_commit_head got=%0h want=1", write_ROB_id); end
    total++; if (new_ROB_id !== 3'd2) begin bad++; $display("FAIL post_commit_tail got=%0h want=2", new_ROB_id); end
    total++; if (write_reg_id !== 5'd0) begin bad++; $display("FAIL post_commit_no_write got=%0h want=0", write_reg_id); end
    cycle_end();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < D; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1); issue_pc = 32'h1000 + 32'(4 * i);
      settle();
      total++; if (issue_ready !== 1'b1 || new_ROB_id !== 3'(i)) begin bad++; $display("FAIL fill_issue%0d got ready=%0h id=%0h want ready=1 id=%0h", i, issue_ready, new_ROB_id, i); end
      cycle_end();
    end
    issue_rd = 5'd20;
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_issue_ready got=%0h want=0", issue_ready); end
    total++; if (new_reg_id !== 5'd0) begin bad++; $display("FAIL full_new_reg_id got=%0h want=0", new_reg_id); end
    cycle_end();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h55;
    settle();
    cycle_end();
    cdb_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_pc = 32'h2000;
    settle();
    total++; if (write_reg_id !== 5'd1) begin bad++; $display("FAIL full_commit_reg got=%0h want=1", write_reg_id); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_commit_issue_ready got=%0h want=0", issue_ready); end
    cycle_end();
    settle();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL wrap_issue_ready got=%0h want=1", issue_ready); end
    total++; if (new_ROB_id !== 3'd0) begin bad++; $display("FAIL wrap_new_ROB_id got=%0h want=0", new_ROB_id); end
    total++; if (new_reg_id !== 5'd9) begin bad++; $display("FAIL wrap_new_reg_id got=%0h want=9", new_reg_id); end
    cycle_end();
    issue_valid = 1'b0;
  endtask

  task automatic test_bypass();
    // buffer holds ids 1..7 and 0, none with a result yet
    rs1_id = 3'd2; rs2_id = 3'd3;
    cdb_valid = 1'b1; cdb_rob_id = 3'd2; cdb_val = 32'd7;
    settle();
    total++; if (rs1_ready !== 1'b1) begin bad++; $display("FAIL bypass_rs1_ready got=%0h want=1", rs1_ready); end
    total++; if (rs1_val !== 32'd7) begin bad++; $display("FAIL bypass_rs1_val got=%0h want=7", rs1_val); end
    total++; if (rs2_ready !== 1'b0) begin bad++; $display("FAIL nobypass_rs2_ready got=%0h want=0", rs2_ready); end
    cycle_end();
    cdb_valid = 1'b0;
    settle();
    total++; if (rs1_ready !== 1'b1 || rs1_val !== 32'd7) begin bad++; $display("FAIL stored_rs1 got ready=%0h val=%0h want ready=1 val=7", rs1_ready, rs1_val); end
    cycle_end();
  endtask

  task automatic test_mispredict();
    do_reset();
    issue_valid = 1'b1; issue_is_br = 1'b1; issue_pred_taken = 1'b0; issue_rd = 5'd0; issue_pc = 32'h200;
    settle(); cycle_end();
    issue_is_br = 1'b0; issue_rd = 5'd7; issue_pc = 32'h204;
    settle(); cycle_end();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h300; cdb_br_taken = 1'b1;
    settle(); cycle_end();
    cdb_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd11; issue_pc = 32'h400;
    settle();
    total++; if (clear_flag !== 1'b1) begin bad++; $display("FAIL mispred_taken_clear got=%0h want=1", clear_flag); end
    total++; if (redirect_pc !== 32'h300) begin bad++; $display("FAIL mispred_taken_redirect got=%0h want=300", redirect_pc); end
    total++; if (issue_ready !== 1'b0 || new_reg_id !== 5'd0) begin bad++; $display("FAIL mispred_issue_block got ready=%0h reg=%0h want 0 0", issue_ready, new_reg_id); end
    total++; if (write_reg_id !== 5'd0) begin bad++; $display("FAIL mispred_branch_write got=%0h want=0", write_reg_id); end
    cycle_end();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h77;
    settle();
    total++; if (new_ROB_id !== 3'd0 || clear_flag !== 1'b0) begin bad++; $display("FAIL post_flush got id=%0h clear=%0h want id=0 clear=0", new_ROB_id, clear_flag); end
    cycle_end();
    cdb_valid = 1'b0;
    settle();
    total++; if (write_reg_id !== 5'd0) begin bad++; $display("FAIL flushed_entry_commit got=%0h want=0", write_reg_id); end
    cycle_end();
    // predicted taken, actually not taken: restart at pc+4
    issue_valid = 1'b1; issue_is_br = 1'b1; issue_pred_taken = 1'b1; issue_rd = 5'd0; issue_pc = 32'h200;
    settle(); cycle_end();
    issue_valid = 1'b0; issue_is_br = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h999; cdb_br_taken = 1'b0;
    settle(); cycle_end();
    cdb_valid = 1'b0;
    settle();
    total++; if (clear_flag !== 1'b1) begin bad++; $display("FAIL mispred_nt_clear got=%0h want=1", clear_flag); end
    total++; if (redirect_pc !== 32'h204) begin bad++; $display("FAIL mispred_nt_redirect got=%0h want=204", redirect_pc); end
    cycle_end();
    // correctly predicted branch retires without a flush
    issue_valid = 1'b1; issue_is_br = 1'b1; issue_pred_taken = 1'b1; issue_rd = 5'd0; issue_pc = 32'h300;
    settle(); cycle_end();
    issue_valid = 1'b0; issue_is_br = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h500; cdb_br_taken = 1'b1;
    settle(); cycle_end();
    cdb_valid = 1'b0;
    settle();
    total++; if (clear_flag !== 1'b0 || write_reg_id !== 5'd0 || write_ROB_id !== 3'd0) begin bad++; $display("FAIL good_branch got clear=%0h reg=%0h id=%0h want 0 0 0", clear_flag, write_reg_id, write_ROB_id); end
    cycle_end();
    settle();
    total++; if (write_ROB_id !== 3'd1 || new_ROB_id !== 3'd1) begin bad++; $display("FAIL good_branch_retired got head=%0h tail=%0h want 1 1", write_ROB_id, new_ROB_id); end
    cycle_end();
  endtask

  task automatic test_pause_reset();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3; issue_pc = 32'h600;
    settle(); cycle_end();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd0; cdb_val = 32'h33;
    settle(); cycle_end();
    cdb_valid = 1'b0;
    rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4;
    for (int i = 0; i < 2; i++) begin
      settle();
      total++; if (write_reg_id !== 5'd0 || new_reg_id !== 5'd0 || clear_flag !== 1'b0 || issue_ready !== 1'b0) begin bad++; $display("FAIL pause_outputs got wr=%0h nr=%0h cl=%0h ir=%0h want 0 0 0 0", write_reg_id, new_reg_id, clear_flag, issue_ready); end
      cycle_end();
    end
    rdy_in = 1'b1; issue_valid = 1'b0;
    settle();
    total++; if (write_reg_id !== 5'd3 || write_ROB_id !== 3'd0 || new_ROB_id !== 3'd1) begin bad++; $display("FAIL pause_resume got wr=%0h head=%0h tail=%0h want 3 0 1", write_reg_id, write_ROB_id, new_ROB_id); end
    cycle_end();
    issue_valid = 1'b1; issue_rd = 5'd8;
    for (int i = 0; i < 3; i++) begin settle(); cycle_end(); end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h1;
    settle(); cycle_end();
    rst_in = 1'b0;
    settle(); cycle_end();
    rst_in = 1'b1;
    settle();
    total++; if (new_ROB_id !== 3'd0 || write_ROB_id !== 3'd0 || write_reg_id !== 5'd0 || issue_ready !== 1'b1) begin bad++; $display("FAIL reset_busy got tail=%0h head=%0h wr=%0h ir=%0h want 0 0 0 1", new_ROB_id, write_ROB_id, write_reg_id, issue_ready); end
    cycle_end();
    cdb_valid = 1'b0;
  endtask

  task automatic test_random();
    int sz;
    for (int n = 0; n < 600; n++) begin
      sz = q.size();
      rst_in           = ($urandom_range(0, 63) != 0);
      rdy_in           = ($urandom_range(0, 9) != 0);
      issue_valid      = ($urandom_range(0, 9) < 6);
      issue_rd         = 5'($urandom);
      issue_is_br      = ($urandom_range(0, 4) == 0);
      issue_pred_taken = 1'($urandom);
      issue_pc         = $urandom & 32'hFFFF_FFFC;
      cdb_valid        = ($urandom_range(0, 1) == 1);
      if (sz > 0 && $urandom_range(0, 3) != 0)
        cdb_rob_id = W'((head_id + $urandom_range(0, sz - 1)) % D);
      else
        cdb_rob_id = W'($urandom);
      cdb_val      = $urandom;
      cdb_br_taken = 1'($urandom);
      rs1_id       = W'($urandom);
      rs2_id       = W'($urandom);
      settle();
      total++; if (issue_ready !== m_iready) begin bad++; $display("FAIL rnd%0d issue_ready got=%0h want=%0h", n, issue_ready, m_iready); end
      total++; if (new_reg_id !== m_new_reg) begin bad++; $display("FAIL rnd%0d new_reg_id got=%0h want=%0h", n, new_reg_id, m_new_reg); end
      total++; if (new_ROB_id !== W'(m_new_id)) begin bad++; $display("FAIL rnd%0d new_ROB_id got=%0h want=%0h", n, new_ROB_id, m_new_id); end
      total++; if (write_reg_id !== m_wreg) begin bad++; $display("FAIL rnd%0d write_reg_id got=%0h want=%0h", n, write_reg_id, m_wreg); end
      total++; if (write_ROB_id !== W'(m_wid)) begin bad++; $display("FAIL rnd%0d write_ROB_id got=%0h want=%0h", n, write_ROB_id, m_wid); end
      total++; if (clear_flag !== m_clear) begin bad++; $display("FAIL rnd%0d clear_flag got=%0h want=%0h", n, clear_flag, m_clear); end
      if (m_commit) begin
        total++; if (write_val !== m_wval) begin bad++; $display("FAIL rnd%0d write_val got=%0h want=%0h", n, write_val, m_wval); end
      end
      if (m_clear) begin
        total++; if (redirect_pc !== m_redirect) begin bad++; $display("FAIL rnd%0d redirect_pc got=%0h want=%0h", n, redirect_pc, m_redirect); end
      end
      if (m_rs1_chk) begin
        total++; if (rs1_ready !== m_rs1_rdy || (m_rs1_rdy && rs1_val !== m_rs1_val)) begin bad++; $display("FAIL rnd%0d rs1 got rdy=%0h val=%0h want rdy=%0h val=%0h", n, rs1_ready, rs1_val, m_rs1_rdy, m_rs1_val); end
      end
      if (m_rs2_chk) begin
        total++; if (rs2_ready !== m_rs2_rdy || (m_rs2_rdy && rs2_val !== m_rs2_val)) begin bad++; $display("FAIL rnd%0d rs2 got rdy=%0h val=%0h want rdy=%0h val=%0h", n, rs2_ready, rs2_val, m_rs2_rdy, m_rs2_val); end
      end
      cycle_end();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_issue_basic();
    test_cdb_commit();
    test_full_wrap();
    test_bypass();
    test_mispredict();
    test_pause_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
